// File: rtl/parking_action_ctrl_pkg.sv
// Shared encodings for the parking gate sequencing controller:
// actions, request modes, error codes and controller states.
package parking_action_ctrl_pkg;

    typedef enum logic [2:0] {
        ACT_NONE       = 3'd0,
        ACT_ALT_FLR    = 3'd1,
        ACT_CHOSEN_FLR = 3'd2,
        ACT_EXIT       = 3'd3,
        ACT_RESTRICT   = 3'd4,
        ACT_UNRESTRICT = 3'd5
    } action_e;

    typedef enum logic [1:0] {
        MODE_ENTER = 2'd0,
        MODE_EXIT  = 2'd1,
        MODE_ADMIN = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ERR_NONE           = 3'd0,
        ERR_INVALID_ID     = 3'd1,
        ERR_FULL           = 3'd2,
        ERR_ALT            = 3'd3,
        ERR_ADMIN_DENIED   = 3'd4,
        ERR_TARGET_UNKNOWN = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CHECK       = 3'd1,
        ST_ALT_WAIT    = 3'd2,
        ST_ADMIN_WAIT  = 3'd3,
        ST_ADMIN_CHECK = 3'd4,
        ST_GATE        = 3'd5
    } state_e;

endpackage

// File: rtl/parking_action_ctrl_space_counter.sv
// 3-bit free-space counter that resets to its capacity and saturates at 0 and CAP.
module parking_action_ctrl_space_counter
    import parking_action_ctrl_pkg::*;
#(
    parameter int unsigned CAP = 7
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [2:0] o_count
);

    logic [2:0] r_count;

    // Simultaneous inc/dec cancels; out-of-range steps are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 3'(CAP);
        end else if (i_inc && !i_dec && (r_count < 3'(CAP))) begin
            r_count <= r_count + 3'd1;
        end else if (i_dec && !i_inc && (r_count != 3'd0)) begin
            r_count <= r_count - 3'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/parking_action_ctrl.sv
// Entry/exit/admin request sequencer for the parking gate: decides the action,
// owns the per-floor free-space counters and drives gate and error indications.
module parking_action_ctrl
    import parking_action_ctrl_pkg::*;
#(
    parameter int unsigned SPEC0_CAP   = 2,
    parameter int unsigned NORM0_CAP   = 5,
    parameter int unsigned FLR1_CAP    = 7,
    parameter int unsigned GATE_CYCLES = 4,
    parameter int unsigned ALT_TIMEOUT = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] MODE,
    input  logic       id_submit,
    input  logic       chosen_flr,
    input  logic       alt_accept,
    input  logic       alt_decline,
    input  logic       restrict_req,
    input  logic       id_valid,
    input  logic       id_special,
    input  logic       chosen_flr_full,
    input  logic       alternative_flr_full,
    input  logic       adminId_valid,
    input  logic       id_restricted,
    input  logic       id_exists,
    input  logic       user_in_floor,
    output logic [2:0] action_taken,
    output logic [2:0] remain_flr_spec_0,
    output logic [2:0] remain_flr_norm_0,
    output logic [2:0] remain_flr_1,
    output logic       alt_offer,
    output logic       gate_open,
    output logic       busy,
    output logic [2:0] err_code
);

    state_e     r_state;
    state_e     w_state_nxt;
    action_e    r_action;
    action_e    w_action_nxt;
    err_e       r_err;
    err_e       w_err_nxt;
    logic [7:0] r_tmr;
    logic [7:0] w_tmr_nxt;
    logic       r_alt_offer;
    logic       r_gate;
    logic       r_busy;
    // Counter strobes, bit 0 special floor 0, bit 1 normal floor 0, bit 2 floor 1.
    logic [2:0] w_inc;
    logic [2:0] w_dec;
    logic       w_unused;

    assign w_unused = id_restricted;

    // Next-state, action, error and counter-strobe decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_action_nxt = ACT_NONE;
        w_err_nxt    = r_err;
        w_inc        = 3'b000;
        w_dec        = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (id_submit) begin
                    w_err_nxt   = ERR_NONE;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
                case (mode_e'(MODE))
                    MODE_ENTER: begin
                        if (id_special) begin
                            if (remain_flr_spec_0 != 3'd0) begin
                                w_action_nxt = ACT_CHOSEN_FLR;
                                w_dec        = 3'b001;
                                w_state_nxt  = ST_GATE;
                            end else begin
                                w_err_nxt = ERR_FULL;
                            end
                        end else if (!id_valid) begin
                            w_err_nxt = ERR_INVALID_ID;
                        end else if (!chosen_flr_full) begin
                            w_action_nxt = ACT_CHOSEN_FLR;
                            w_dec        = chosen_flr ? 3'b100 : 3'b010;
                            w_state_nxt  = ST_GATE;
                        end else if (!alternative_flr_full) begin
                            w_state_nxt = ST_ALT_WAIT;
                        end else begin
                            w_err_nxt = ERR_FULL;
                        end
                    end
                    MODE_EXIT: begin
                        if (!id_valid && !id_special) begin
                            w_err_nxt = ERR_INVALID_ID;
                        end else begin
                            w_action_nxt = ACT_EXIT;
                            w_inc        = id_special ? 3'b001 : (user_in_floor ? 3'b100 : 3'b010);
                            w_state_nxt  = ST_GATE;
                        end
                    end
                    MODE_ADMIN: begin
                        if (adminId_valid) begin
                            w_state_nxt = ST_ADMIN_WAIT;
                        end else begin
                            w_err_nxt = ERR_ADMIN_DENIED;
                        end
                    end
                    default: begin
                        w_err_nxt = ERR_INVALID_ID;
                    end
                endcase
            end
            ST_ALT_WAIT: begin
                // Decline has priority over a same-cycle accept.
                if (alt_decline) begin
                    w_err_nxt   = ERR_ALT;
                    w_state_nxt = ST_IDLE;
                end else if (alt_accept) begin
                    w_action_nxt = ACT_ALT_FLR;
                    w_dec        = chosen_flr ? 3'b010 : 3'b100;
                    w_state_nxt  = ST_GATE;
                end else if (r_tmr == 8'(ALT_TIMEOUT - 1)) begin
                    w_err_nxt   = ERR_ALT;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ALT_WAIT;
                end
            end
            ST_ADMIN_WAIT: begin
                if (id_submit) begin
                    w_err_nxt   = ERR_NONE;
                    w_state_nxt = ST_ADMIN_CHECK;
                end else begin
                    w_state_nxt = ST_ADMIN_WAIT;
                end
            end
            ST_ADMIN_CHECK: begin
                w_state_nxt = ST_IDLE;
                if (!id_exists) begin
                    w_err_nxt = ERR_TARGET_UNKNOWN;
                end else begin
                    w_action_nxt = restrict_req ? ACT_RESTRICT : ACT_UNRESTRICT;
                end
            end
            ST_GATE: begin
                if (r_tmr == 8'(GATE_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GATE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if ((w_state_nxt == r_state) && ((r_state == ST_ALT_WAIT) || (r_state == ST_GATE))) begin
            w_tmr_nxt = r_tmr + 8'd1;
        end else begin
            w_tmr_nxt = 8'd0;
        end
    end

    // State, timer and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_action    <= ACT_NONE;
            r_err       <= ERR_NONE;
            r_tmr       <= 8'd0;
            r_alt_offer <= 1'b0;
            r_gate      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_action    <= w_action_nxt;
            r_err       <= w_err_nxt;
            r_tmr       <= w_tmr_nxt;
            r_alt_offer <= (w_state_nxt == ST_ALT_WAIT);
            r_gate      <= (w_state_nxt == ST_GATE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    parking_action_ctrl_space_counter #(.CAP(SPEC0_CAP)) u_cnt_spec_0 (
        .i_clk(CLK), .i_rst(RST), .i_inc(w_inc[0]), .i_dec(w_dec[0]), .o_count(remain_flr_spec_0)
    );
    parking_action_ctrl_space_counter #(.CAP(NORM0_CAP)) u_cnt_norm_0 (
        .i_clk(CLK), .i_rst(RST), .i_inc(w_inc[1]), .i_dec(w_dec[1]), .o_count(remain_flr_norm_0)
    );
    parking_action_ctrl_space_counter #(.CAP(FLR1_CAP)) u_cnt_flr_1 (
        .i_clk(CLK), .i_rst(RST), .i_inc(w_inc[2]), .i_dec(w_dec[2]), .o_count(remain_flr_1)
    );

    assign action_taken = r_action;
    assign err_code     = r_err;
    assign alt_offer    = r_alt_offer;
    assign gate_open    = r_gate;
    assign busy         = r_busy;

endmodule

// File: tb/tb_parking_action_ctrl.sv
// Scenario tests plus a randomized run against a rule-level model of the
// parking controller (free-space table, expected action/error per request).
module tb_parking_action_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] MODE = 2'd0;
    logic       id_submit = 1'b0, chosen_flr = 1'b0, alt_accept = 1'b0, alt_decline = 1'b0;
    logic       restrict_req = 1'b0, id_valid = 1'b0, id_special = 1'b0, chosen_flr_full = 1'b0;
    logic       alternative_flr_full = 1'b0, adminId_valid = 1'b0, id_restricted = 1'b0;
    logic       id_exists = 1'b0, user_in_floor = 1'b0;
    logic [2:0] action_taken, remain_flr_spec_0, remain_flr_norm_0, remain_flr_1, err_code;
    logic       alt_offer, gate_open, busy;

    int n_checks = 0;
    int n_fail   = 0;
    // Free spaces: index 0 special floor 0, 1 normal floor 0, 2 floor 1.
    int cap[3] = '{2, 5, 7};
    int cnt[3];

    always #5 CLK = ~CLK;

    parking_action_ctrl #(
        .SPEC0_CAP(2), .NORM0_CAP(5), .FLR1_CAP(7), .GATE_CYCLES(4), .ALT_TIMEOUT(8)
    ) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .id_submit(id_submit), .chosen_flr(chosen_flr),
        .alt_accept(alt_accept), .alt_decline(alt_decline), .restrict_req(restrict_req),
        .id_valid(id_valid), .id_special(id_special), .chosen_flr_full(chosen_flr_full),
        .alternative_flr_full(alternative_flr_full), .adminId_valid(adminId_valid),
        .id_restricted(id_restricted), .id_exists(id_exists), .user_in_floor(user_in_floor),
        .action_taken(action_taken), .remain_flr_spec_0(remain_flr_spec_0),
        .remain_flr_norm_0(remain_flr_norm_0), .remain_flr_1(remain_flr_1),
        .alt_offer(alt_offer), .gate_open(gate_open), .busy(busy), .err_code(err_code)
    );

    function automatic logic [8:0] exp_cnt();
        return {3'(cnt[0]), 3'(cnt[1]), 3'(cnt[2])};
    endfunction

    function automatic void model_take(int i);
        if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
    endfunction

    function automatic void model_free(int i);
        if (cnt[i] < cap[i]) cnt[i] = cnt[i] + 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) cnt[i] = cap[i];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_submit();
        id_submit = 1'b1;
        tick();
        id_submit = 1'b0;
    endtask

    task automatic clear_inputs();
        MODE = 2'd0; chosen_flr = 1'b0; alt_accept = 1'b0; alt_decline = 1'b0;
        restrict_req = 1'b0; id_valid = 1'b0; id_special = 1'b0; chosen_flr_full = 1'b0;
        alternative_flr_full = 1'b0; adminId_valid = 1'b0; id_restricted = 1'b0;
        id_exists = 1'b0; user_in_floor = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        model_reset();
        n_checks++;
        if (action_taken !== 3'd0) begin
            n_fail++; $display("FAIL reset_action: got %0d want 0", action_taken);
        end
        n_checks++;
        if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== exp_cnt()) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 2/5/7",
                               remain_flr_spec_0, remain_flr_norm_0, remain_flr_1);
        end
        n_checks++;
        if ({alt_offer, gate_open, busy, err_code} !== 6'd0) begin
            n_fail++; $display("FAIL reset_status: alt=%b gate=%b busy=%b err=%0d want all 0",
                               alt_offer, gate_open, busy, err_code);
        end
    endtask

    task automatic test_enter_normal();
        int g, a;
        bit ok;
        clear_inputs();
        MODE = 2'd0; chosen_flr = 1'b1; id_valid = 1'b1;
        pulse_submit();
        tick();
        model_take(2);
        n_checks++;
        if (action_taken !== 3'd2) begin
            n_fail++; $display("FAIL enter_action_t2: got %0d want 2", action_taken);
        end
        n_checks++;
        if (remain_flr_1 !== 3'(cnt[2])) begin
            n_fail++; $display("FAIL enter_flr1: got %0d want %0d", remain_flr_1, cnt[2]);
        end
        g = 0; a = 0;
        while (gate_open && g < 20) begin
            g++;
            if (action_taken !== 3'd0) a++;
            tick();
        end
        n_checks++;
        if (g != 4) begin
            n_fail++; $display("FAIL enter_gate_len: got %0d want 4", g);
        end
        n_checks++;
        if (a != 1) begin
            n_fail++; $display("FAIL enter_action_pulse: got %0d cycles want 1", a);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL enter_idle: busy stuck got 1 want 0");
        end
    endtask

    task automatic test_alt_accept();
        bit ok;
        clear_inputs();
        MODE = 2'd0; chosen_flr = 1'b0; id_valid = 1'b1; chosen_flr_full = 1'b1;
        pulse_submit();
        tick();
        n_checks++;
        if (alt_offer !== 1'b1 || action_taken !== 3'd0) begin
            n_fail++; $display("FAIL alt_offer: got alt=%b act=%0d want alt=1 act=0", alt_offer, action_taken);
        end
        tick();
        alt_accept = 1'b1;
        tick();
        alt_accept = 1'b0;
        model_take(2);
        n_checks++;
        if (action_taken !== 3'd1) begin
            n_fail++; $display("FAIL alt_accept_action: got %0d want 1", action_taken);
        end
        n_checks++;
        if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== exp_cnt()) begin
            n_fail++; $display("FAIL alt_accept_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                               remain_flr_spec_0, remain_flr_norm_0, remain_flr_1, cnt[0], cnt[1], cnt[2]);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL alt_accept_idle: busy stuck got 1 want 0");
        end
    endtask

    task automatic test_alt_timeout();
        int w, a;
        clear_inputs();
        MODE = 2'd0; chosen_flr = 1'b0; id_valid = 1'b1; chosen_flr_full = 1'b1;
        pulse_submit();
        tick();
        w = 0; a = 0;
        while (alt_offer && w < 40) begin
            w++;
            if (action_taken !== 3'd0) a++;
            tick();
        end
        n_checks++;
        if (w != 8) begin
            n_fail++; $display("FAIL alt_timeout_len: got %0d want 8", w);
        end
        n_checks++;
        if (err_code !== 3'd3 || action_taken !== 3'd0 || a != 0) begin
            n_fail++; $display("FAIL alt_timeout_err: got err=%0d actions=%0d want err=3 actions=0",
                               err_code, a);
        end
        n_checks++;
        if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== exp_cnt()) begin
            n_fail++; $display("FAIL alt_timeout_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                               remain_flr_spec_0, remain_flr_norm_0, remain_flr_1, cnt[0], cnt[1], cnt[2]);
        end
    endtask

    task automatic test_special_enter();
        int exp_act, exp_err;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            MODE = 2'd0; id_special = 1'b1; id_valid = 1'b1;
            pulse_submit();
            tick();
            if (cnt[0] > 0) begin
                exp_act = 2; exp_err = 0; model_take(0);
            end else begin
                exp_act = 0; exp_err = 2;
            end
            n_checks++;
            if (action_taken !== 3'(exp_act) || err_code !== 3'(exp_err)) begin
                n_fail++; $display("FAIL special_%0d: got act=%0d err=%0d want act=%0d err=%0d",
                                   k, action_taken, err_code, exp_act, exp_err);
            end
            n_checks++;
            if (remain_flr_spec_0 !== 3'(cnt[0])) begin
                n_fail++; $display("FAIL special_cnt_%0d: got %0d want %0d", k, remain_flr_spec_0, cnt[0]);
            end
            wait_idle(ok);
        end
    endtask

    task automatic test_exit_saturation();
        bit ok;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            MODE = 2'd1; id_valid = 1'b1; user_in_floor = 1'b1;
            pulse_submit();
            tick();
            model_free(2);
            n_checks++;
            if (action_taken !== 3'd3 || remain_flr_1 !== 3'(cnt[2])) begin
                n_fail++; $display("FAIL exit_%0d: got act=%0d flr1=%0d want act=3 flr1=%0d",
                                   k, action_taken, remain_flr_1, cnt[2]);
            end
            wait_idle(ok);
        end
    endtask

    task automatic test_admin_restrict();
        int g;
        clear_inputs();
        MODE = 2'd2; adminId_valid = 1'b1;
        pulse_submit();
        tick();
        g = 0;
        n_checks++;
        if (busy !== 1'b1 || action_taken !== 3'd0) begin
            n_fail++; $display("FAIL admin_wait: got busy=%b act=%0d want busy=1 act=0", busy, action_taken);
        end
        tick();
        if (gate_open) g++;
        adminId_valid = 1'b0; id_exists = 1'b1; restrict_req = 1'b1;
        pulse_submit();
        if (gate_open) g++;
        tick();
        if (gate_open) g++;
        n_checks++;
        if (action_taken !== 3'd4 || g != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL admin_restrict: got act=%0d gate_cycles=%0d busy=%b want 4/0/0",
                               action_taken, g, busy);
        end
        n_checks++;
        if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== exp_cnt()) begin
            n_fail++; $display("FAIL admin_counters: counters changed by admin op");
        end
    endtask

    task automatic test_ignore_while_busy();
        int a;
        bit ok;
        clear_inputs();
        MODE = 2'd0; chosen_flr = 1'b0; id_valid = 1'b1;
        pulse_submit();
        tick();
        model_take(1);
        MODE = 2'd1; user_in_floor = 1'b0;
        pulse_submit();
        a = 0;
        for (int k = 0; k < 12; k++) begin
            if (action_taken !== 3'd0) a++;
            tick();
        end
        n_checks++;
        if (a != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_busy: got actions=%0d busy=%b want 0/0", a, busy);
        end
        n_checks++;
        if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== exp_cnt()) begin
            n_fail++; $display("FAIL ignore_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                               remain_flr_spec_0, remain_flr_norm_0, remain_flr_1, cnt[0], cnt[1], cnt[2]);
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid_alt();
        clear_inputs();
        MODE = 2'd0; chosen_flr = 1'b1; id_valid = 1'b1; chosen_flr_full = 1'b1;
        pulse_submit();
        tick();
        n_checks++;
        if (alt_offer !== 1'b1) begin
            n_fail++; $display("FAIL midreset_setup: alt_offer got %b want 1", alt_offer);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        n_checks++;
        if ({alt_offer, gate_open, busy} !== 3'b000 || action_taken !== 3'd0 || err_code !== 3'd0) begin
            n_fail++; $display("FAIL midreset_status: got alt=%b gate=%b busy=%b act=%0d err=%0d want zeros",
                               alt_offer, gate_open, busy, action_taken, err_code);
        end
        n_checks++;
        if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== exp_cnt()) begin
            n_fail++; $display("FAIL midreset_counters: got %0d/%0d/%0d want 2/5/7",
                               remain_flr_spec_0, remain_flr_norm_0, remain_flr_1);
        end
    endtask

    task automatic test_random();
        int kind, exp_act, exp_err, d, ans;
        bit ok;
        for (int it = 0; it < 80; it++) begin
            clear_inputs();
            MODE = 2'($urandom_range(0, 3));
            chosen_flr = 1'($urandom); id_valid = ($urandom_range(0, 3) != 0);
            id_special = ($urandom_range(0, 3) == 0); chosen_flr_full = 1'($urandom);
            alternative_flr_full = 1'($urandom); adminId_valid = 1'($urandom);
            user_in_floor = 1'($urandom); id_restricted = 1'($urandom);
            // kind: 0 error, 1 commit, 2 alternative offer, 3 admin target wait
            kind = 0; exp_act = 0; exp_err = 0;
            case (MODE)
                2'd0: begin
                    if (id_special) begin
                        if (cnt[0] > 0) begin kind = 1; exp_act = 2; model_take(0); end
                        else exp_err = 2;
                    end else if (!id_valid) exp_err = 1;
                    else if (!chosen_flr_full) begin
                        kind = 1; exp_act = 2; model_take(chosen_flr ? 2 : 1);
                    end else if (!alternative_flr_full) kind = 2;
                    else exp_err = 2;
                end
                2'd1: begin
                    if (!id_valid && !id_special) exp_err = 1;
                    else begin
                        kind = 1; exp_act = 3;
                        model_free(id_special ? 0 : (user_in_floor ? 2 : 1));
                    end
                end
                2'd2: begin
                    if (adminId_valid) kind = 3;
                    else exp_err = 4;
                end
                default: exp_err = 1;
            endcase
            pulse_submit();
            tick();
            if (kind == 2) begin
                d = $urandom_range(0, 10);
                ans = $urandom_range(0, 2);
                for (int k = 0; k < d && k < 8; k++) tick();
                if (d < 8) begin
                    alt_accept = (ans != 1); alt_decline = (ans != 0);
                    tick();
                    alt_accept = 1'b0; alt_decline = 1'b0;
                    if (ans == 0) begin exp_act = 2'd1; model_take(chosen_flr ? 1 : 2); end
                    else exp_err = 3;
                end else begin
                    exp_err = 3;
                    while (alt_offer && d < 40) begin tick(); d++; end
                end
            end else if (kind == 3) begin
                id_exists = 1'($urandom); restrict_req = 1'($urandom);
                tick();
                pulse_submit();
                tick();
                if (id_exists) exp_act = restrict_req ? 4 : 5;
                else exp_err = 5;
            end
            n_checks++;
            if (action_taken !== 3'(exp_act) || err_code !== 3'(exp_err)) begin
                n_fail++; $display("FAIL random_%0d mode=%0d: got act=%0d err=%0d want act=%0d err=%0d",
                                   it, MODE, action_taken, err_code, exp_act, exp_err);
            end
            n_checks++;
            if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== exp_cnt()) begin
                n_fail++; $display("FAIL random_cnt_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", it,
                                   remain_flr_spec_0, remain_flr_norm_0, remain_flr_1, cnt[0], cnt[1], cnt[2]);
            end
            wait_idle(ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL random_idle_%0d: busy got 1 want 0", it);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_enter_normal();
        test_alt_accept();
        test_alt_timeout();
        test_special_enter();
        test_exit_saturation();
        test_admin_restrict();
        test_ignore_while_busy();
        test_reset_mid_alt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_action_ctrl.md
Name: parking_action_ctrl

Overview:
Sequencing controller for the parking entry/exit gate. It sits in front of the floor/ID status logic and is its command source. It consumes that block's ID status flags, decides the action per request, and drives action_taken back to it. It owns the per-floor free-space counters (remain_flr_*) and drives the gate and error indications.

Parameters:
SPEC0_CAP, 2, special-user capacity on floor 0 (max 7)
NORM0_CAP, 5, normal capacity on floor 0 (max 7)
FLR1_CAP, 7, capacity on floor 1 (max 7)
GATE_CYCLES, 4, cycles gate_open stays high after an enter or exit commit
ALT_TIMEOUT, 8, cycles to wait for an alternative-floor answer

Ports:
CLK  in  1  clock; all state changes on posedge
RST  in  1  synchronous, active-high reset
MODE  in  2  0 enter, 1 exit, 2 admin; sampled on id_submit
id_submit  in  1  one-cycle request strobe; upstream holds ID/MODE/chosen_flr stable until busy falls
chosen_flr  in  1  requested floor (0/1), enter mode
alt_accept  in  1  user accepts offered alternative floor
alt_decline  in  1  user declines offered alternative floor
restrict_req  in  1  admin target op: 1 restrict, 0 unrestrict
id_valid, id_special, chosen_flr_full, alternative_flr_full, adminId_valid, id_restricted, id_exists, user_in_floor  in  1 each  status flags from floor/ID logic
action_taken  out  3  0 none, 1 alt floor, 2 chosen floor, 3 exit, 4 restrict, 5 unrestrict
remain_flr_spec_0, remain_flr_norm_0, remain_flr_1  out  3 each  free spaces
alt_offer  out  1  high while waiting for the alternative answer
gate_open  out  1  gate drive
busy  out  1  high in every state except IDLE
err_code  out  3  0 none, 1 invalid ID, 2 full, 3 alt declined/timeout, 4 admin denied, 5 target unknown

Behaviour:
- Reset: state IDLE; action_taken=0; counters = SPEC0_CAP/NORM0_CAP/FLR1_CAP; alt_offer, gate_open, busy, err_code all 0; timers cleared. RST applied mid-operation aborts without emitting any action.
- States: IDLE, CHECK, ALT_WAIT, ADMIN_WAIT, ADMIN_CHECK, GATE.
- IDLE: on id_submit, clear err_code and go to CHECK. Flags are sampled in CHECK, one cycle after submit.
- CHECK, MODE=0 (enter):
  - id_special: if spec_0>0, action 2 and spec_0-- → GATE; else err 2 → IDLE.
  - !id_valid: err 1 → IDLE.
  - !chosen_flr_full: action 2, decrement counter of chosen_flr → GATE.
  - else if !alternative_flr_full: go to ALT_WAIT.
  - else err 2 → IDLE.
- CHECK, MODE=1 (exit):
  - !id_valid && !id_special: err 1 → IDLE.
  - else action 3 and increment spec_0 if id_special, otherwise flr_1 if user_in_floor, otherwise norm_0 → GATE.
- CHECK, MODE=2 (admin): adminId_valid → ADMIN_WAIT; else err 4 → IDLE.
- CHECK, MODE=3: err 1 → IDLE.
- ALT_WAIT:
  - alt_offer=1; timer counts.
  - alt_accept → action 1 and decrement counter of !chosen_flr → GATE.
  - alt_decline, or timer reaching ALT_TIMEOUT with no answer → err 3 → IDLE.
  - Accept and decline in the same cycle: decline wins.
- ADMIN_WAIT: next id_submit (target ID on bus) → ADMIN_CHECK.
- ADMIN_CHECK:
  - !id_exists → err 5 → IDLE.
  - else action 4 if restrict_req, 5 otherwise → IDLE.
  - No counter change; no gate.
- action_taken and counter updates are registered on the edge leaving CHECK/ALT_WAIT/ADMIN_CHECK. Both are visible in the same cycle; action_taken is a 1-cycle pulse.
- Latency: submit at cycle T → action visible at T+2 (direct commit).
- GATE: gate_open=1 for exactly GATE_CYCLES cycles, then IDLE.
- Counters saturate: never decrement below 0, never increment above their CAP.
- id_submit outside IDLE/ADMIN_WAIT is ignored.
- err_code holds until the next accepted id_submit.

Decomposition:
Shared package holds the action encoding (ACT_NONE..ACT_UNRESTRICT), the MODE encoding, the err_code encoding and the state encoding. One natural sub-module: space_counter, a 3-bit saturating up/down counter with CAP reset value, instanced three times.

Test Plan:
- Reset, then normal enter with chosen_flr=1 and flags id_valid=1, chosen_flr_full=0 → action_taken=2 at T+2; remain_flr_1 7→6; gate_open high 4 cycles.
- Enter with chosen_flr=0, chosen_flr_full=1, alternative_flr_full=0 → alt_offer=1; alt_accept at +3 → action 1; remain_flr_1 decrements by 1.
- Same setup with no answer for 8 cycles → err_code=3, action_taken stays 0, counters unchanged.
- Special enter three times with SPEC0_CAP=2 → two action 2 pulses, spec_0 2→1→0; third gives err_code=2.
- Exit with user_in_floor=1 at remain_flr_1=6 → action 3, remain_flr_1=7; a second exit at 7 stays at 7 (saturation).
- Admin ID with adminId_valid=1, then target submit with id_exists=1, restrict_req=1 → action 4, gate stays 0. Assert RST during ALT_WAIT → IDLE, counters at CAP values.
